// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: conversion-rate Sync generation, result capture,
// optional 2^AvgLog2 block averaging and a small valid/ready output FIFO
// for the dual-channel AD7674 capture path.
// Build macro: ADC_SCHED_AVERAGE_EN enables the averaging accumulators;
// without it every capture is pushed directly and AvgLog2 is ignored.
//
// state | meaning
// IDLE  | stopped, Sync low, waiting for Enable
// PRIME | first period after enable; its capture is skipped (ADC data stale)
// RUN   | capture every period at phase 8, push at phase 9

module adc_sample_scheduler #(
   parameter int DIV_WIDTH = 10,
   parameter int FIFO_LOG2 = 2
) (
   input  logic                 nReset,
   input  logic                 Clk,
   input  logic                 Enable,
   input  logic [DIV_WIDTH-1:0] Divide,
   input  logic [2:0]           AvgLog2,
   input  logic                 Clear,
   output logic                 Sync,
   input  logic [35:0]          AdcData,
   output logic                 Valid,
   input  logic                 Ready,
   output logic [35:0]          DataOut,
   output logic                 Overflow
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(128);
   localparam logic [DIV_WIDTH-1:0] PH_CAPTURE = DIV_WIDTH'(8);
   localparam logic [DIV_WIDTH-1:0] PH_PUSH    = DIV_WIDTH'(9);
   localparam logic [DIV_WIDTH-1:0] PH_ONE     = DIV_WIDTH'(1);
   localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);
   localparam logic [FIFO_LOG2:0]   CNT_ONE    = (FIFO_LOG2+1)'(1);
   localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t               state;
   logic [DIV_WIDTH-1:0] phase;
   logic [DIV_WIDTH-1:0] period;
   logic [DIV_WIDTH-1:0] div_clamped;
   logic [35:0]          capture;
   logic                 at_push;
   logic                 push_req;
   logic [35:0]          push_data;

   logic [35:0]          mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [FIFO_LOG2:0]   count;
   logic                 fifo_full;
   logic                 pop;
   logic                 push_ok;

   // Periods shorter than the ADC can sustain are stretched to the minimum.
   assign div_clamped = (Divide < MIN_PERIOD) ? MIN_PERIOD : Divide;
   assign at_push     = Enable && (state == RUN) && (phase == PH_PUSH);

   // Sequencer: phase counter, period re-latch at wrap, registered Sync and capture.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         phase   <= '0;
         period  <= MIN_PERIOD;
         Sync    <= 1'b0;
         capture <= '0;
      end else if (!Enable) begin
         state <= IDLE;
         phase <= '0;
         Sync  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state  <= PRIME;
               phase  <= '0;
               period <= div_clamped;
               Sync   <= 1'b0;
            end
            default: begin
               Sync <= (phase < (period >> 1));
               if ((state == RUN) && (phase == PH_CAPTURE)) begin
                  capture <= AdcData;
               end
               if (phase == (period - PH_ONE)) begin
                  phase  <= '0;
                  period <= div_clamped;
                  state  <= RUN;
               end else begin
                  phase <= phase + PH_ONE;
               end
            end
         endcase
      end
   end

`ifdef ADC_SCHED_AVERAGE_EN
   logic signed [24:0] acc0;
   logic signed [24:0] acc1;
   logic signed [24:0] sum0;
   logic signed [24:0] sum1;
   logic signed [17:0] avg0;
   logic signed [17:0] avg1;
   logic [6:0]         blk_cnt;
   logic [6:0]         blk_last;
   logic [2:0]         avg_lat;
   logic [2:0]         avg_eff;

   // A new block picks up AvgLog2 live; later captures in the block use the latched copy.
   assign avg_eff   = (blk_cnt == '0) ? AvgLog2 : avg_lat;
   assign blk_last  = 7'((8'd1 << avg_eff) - 8'd1);
   assign sum0      = acc0 + $signed({{7{capture[35]}}, capture[35:18]});
   assign sum1      = acc1 + $signed({{7{capture[17]}}, capture[17:0]});
   assign avg0      = 18'(sum0 >>> avg_eff);
   assign avg1      = 18'(sum1 >>> avg_eff);
   assign push_req  = at_push && (blk_cnt == blk_last);
   assign push_data = {avg0, avg1};

   // Block accumulators: add each RUN capture, restart after the block's last capture.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         acc0    <= '0;
         acc1    <= '0;
         blk_cnt <= '0;
         avg_lat <= '0;
      end else if (!Enable) begin
         acc0    <= '0;
         acc1    <= '0;
         blk_cnt <= '0;
      end else if (at_push) begin
         if (blk_cnt == '0) begin
            avg_lat <= AvgLog2;
         end
         if (push_req) begin
            acc0    <= '0;
            acc1    <= '0;
            blk_cnt <= '0;
         end else begin
            acc0    <= sum0;
            acc1    <= sum1;
            blk_cnt <= blk_cnt + 7'd1;
         end
      end
   end
`else
   logic unused_avg;

   assign unused_avg = ^AvgLog2;
   assign push_req   = at_push;
   assign push_data  = capture;
`endif

   assign Valid     = (count != '0);
   assign DataOut   = mem[rd_ptr];
   assign fifo_full = (count == FULL_COUNT);
   assign pop       = Valid && Ready;
   // A simultaneous pop frees the slot the push needs, so no word is lost.
   assign push_ok   = push_req && (!fifo_full || pop);

   // Output FIFO with sticky overflow; Clear wins over any push or pop in its cycle.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         Overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (Clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         Overflow <= 1'b0;
      end else begin
         if (push_req && fifo_full && !pop) begin
            Overflow <= 1'b1;
         end
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push_ok && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push_ok) begin
            count <= count - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench for adc_sample_scheduler. A behavioural model tracks the
// period schedule, the capture/push phases and the FIFO as a queue, and every
// cycle the DUT outputs are compared against it. Directed checks cover latency,
// Sync period, divide clamping, overflow, Clear, full-with-pop, reset and
// (when built with ADC_SCHED_AVERAGE_EN) floor averaging.

module tb_adc_sample_scheduler;

   localparam int DIV_WIDTH = 10;
   localparam int FIFO_LOG2 = 2;
   localparam int DEPTH     = 4;

   logic                 nReset;
   logic                 Clk;
   logic                 Enable;
   logic [DIV_WIDTH-1:0] Divide;
   logic [2:0]           AvgLog2;
   logic                 Clear;
   logic                 Sync;
   logic [35:0]          AdcData;
   logic                 Valid;
   logic                 Ready;
   logic [35:0]          DataOut;
   logic                 Overflow;

   adc_sample_scheduler #(
      .DIV_WIDTH (DIV_WIDTH),
      .FIFO_LOG2 (FIFO_LOG2)
   ) dut (
      .nReset   (nReset),
      .Clk      (Clk),
      .Enable   (Enable),
      .Divide   (Divide),
      .AvgLog2  (AvgLog2),
      .Clear    (Clear),
      .Sync     (Sync),
      .AdcData  (AdcData),
      .Valid    (Valid),
      .Ready    (Ready),
      .DataOut  (DataOut),
      .Overflow (Overflow)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit          m_run;
   bit          m_prime;
   int          m_ph;
   int          m_P;
   logic [35:0] m_cap;
   logic [35:0] mq[$];
   bit          m_ov;
   bit          m_sync;
`ifdef ADC_SCHED_AVERAGE_EN
   longint      m_s0;
   longint      m_s1;
   int          m_bn;
   int          m_ba;
`endif

   // stimulus control and measurements
   int          data_mode;
   int          ready_mode;
   logic [35:0] tbl[$];
   int          tcyc;
   int          en_cyc;
   int          first_valid;
   int          last_rise;
   int          rise_gap;
   int          hi_run;
   int          last_hi;
   bit          prev_sync;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp_p(input int d);
      return (d < 128) ? 128 : d;
   endfunction

`ifdef ADC_SCHED_AVERAGE_EN
   function automatic longint sx(input logic [17:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [17:0] floor_avg(input longint s, input int a);
      longint n;
      longint qv;
      n  = longint'(1) << a;
      qv = s / n;
      if (s < 0 && (s % n) != 0) qv = qv - 1;
      return 18'(qv);
   endfunction
`endif

   task automatic model_reset();
      m_run     = 0;
      m_prime   = 0;
      m_ph      = 0;
      m_P       = 128;
      m_cap     = '0;
      mq.delete();
      m_ov      = 0;
      m_sync    = 0;
      prev_sync = 0;
      hi_run    = 0;
`ifdef ADC_SCHED_AVERAGE_EN
      m_s0 = 0;
      m_s1 = 0;
      m_bn = 0;
      m_ba = 0;
`endif
   endtask

   // One clock: drive per-cycle stimulus, predict the edge, then compare.
   task automatic step();
      bit          pop;
      bit          push;
      logic [35:0] pw;
      if (m_run && m_ph == 0) begin
         case (data_mode)
            1: AdcData = AdcData + 36'h0_0004_0001;
            2: AdcData = {4'($urandom), $urandom};
            3: if (tbl.size() > 0) AdcData = tbl.pop_front();
            default: ;
         endcase
      end
      case (ready_mode)
         0: Ready = 1'b0;
         1: Ready = 1'b1;
         2: Ready = 1'($urandom_range(0, 1));
         default: Ready = (m_run && !m_prime && m_ph == 9);
      endcase

      pop  = (mq.size() > 0) && Ready;
      push = m_run && !m_prime && Enable && (m_ph == 9);
      pw   = m_cap;
`ifdef ADC_SCHED_AVERAGE_EN
      if (push) begin
         if (m_bn == 0) m_ba = int'(AvgLog2);
         m_s0 += sx(m_cap[35:18]);
         m_s1 += sx(m_cap[17:0]);
         m_bn++;
         if (m_bn == (1 << m_ba)) begin
            pw   = {floor_avg(m_s0, m_ba), floor_avg(m_s1, m_ba)};
            m_s0 = 0;
            m_s1 = 0;
            m_bn = 0;
         end else begin
            push = 0;
         end
      end
      if (!Enable) begin
         m_s0 = 0;
         m_s1 = 0;
         m_bn = 0;
      end
`endif
      if (Clear) begin
         mq.delete();
         m_ov = 0;
      end else if (push && mq.size() == DEPTH && !pop) begin
         m_ov = 1;
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(pw);
      end
      if (m_run && !m_prime && Enable && m_ph == 8) m_cap = AdcData;
      m_sync = m_run && Enable && (m_ph < m_P / 2);
      if (!Enable) begin
         m_run = 0;
         m_ph  = 0;
      end else if (!m_run) begin
         m_run       = 1;
         m_prime     = 1;
         m_ph        = 0;
         m_P         = clamp_p(int'(Divide));
         en_cyc      = tcyc + 1;
         first_valid = -1;
      end else if (m_ph == m_P - 1) begin
         m_ph    = 0;
         m_P     = clamp_p(int'(Divide));
         m_prime = 0;
      end else begin
         m_ph++;
      end

      @(posedge Clk);
      #1;
      tcyc++;
      check("sync", 36'(Sync), 36'(m_sync));
      check("valid", 36'(Valid), 36'(mq.size() > 0));
      check("overflow", 36'(Overflow), 36'(m_ov));
      if (mq.size() > 0) check("data", DataOut, mq[0]);

      if (Sync && !prev_sync) begin
         rise_gap  = tcyc - last_rise;
         last_rise = tcyc;
      end
      if (Sync) hi_run++;
      else if (prev_sync) begin
         last_hi = hi_run;
         hi_run  = 0;
      end
      prev_sync = Sync;
      if (Valid && first_valid < 0) first_valid = tcyc - en_cyc;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      #3 nReset = 1'b0;
      #1;
      model_reset();
      check("rst_sync", 36'(Sync), 36'(0));
      check("rst_valid", 36'(Valid), 36'(0));
      check("rst_overflow", 36'(Overflow), 36'(0));
      check("rst_data", DataOut, 36'h0);
      #5 nReset = 1'b1;
   endtask

   initial begin
      #(120000 * 20);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nReset      = 1'b1;
      Enable      = 1'b0;
      Clear       = 1'b0;
      Ready       = 1'b1;
      Divide      = 10'd128;
      AvgLog2     = 3'd0;
      AdcData     = 36'h0_0001_0002;
      data_mode   = 0;
      ready_mode  = 1;
      tcyc        = 0;
      en_cyc      = 0;
      first_valid = -1;
      last_rise   = 0;
      rise_gap    = 0;
      last_hi     = 0;
      model_reset();

      // reset state
      #2 nReset = 1'b0;
      #13;
      check("reset_sync", 36'(Sync), 36'(0));
      check("reset_valid", 36'(Valid), 36'(0));
      check("reset_data", DataOut, 36'h0);
      check("reset_overflow", 36'(Overflow), 36'(0));
      #5 nReset = 1'b1;
      repeat (2) step();

      // first result latency, Sync period and duty at P=128
      Enable = 1'b1;
      repeat (300) step();
      check("first_valid_offset", 36'(first_valid), 36'(138));
      check("sync_period_128", 36'(rise_gap), 36'(128));
      check("sync_high_64", 36'(last_hi), 36'(64));

      // Divide below the minimum is clamped
      Divide = 10'd50;
      repeat (400) step();
      check("sync_period_clamped", 36'(rise_gap), 36'(128));

      // longer period takes effect at the next boundary
      Divide = 10'd200;
      repeat (500) step();
      check("sync_period_200", 36'(rise_gap), 36'(200));
      check("sync_high_100", 36'(last_hi), 36'(100));
      Divide = 10'd128;
      repeat (300) step();

      // stalled consumer for six periods: overflow, then drain in order and Clear
      data_mode  = 1;
      ready_mode = 0;
      repeat (6 * 128) step();
      check("overflow_set", 36'(Overflow), 36'(1));
      check("valid_held", 36'(Valid), 36'(1));
      ready_mode = 1;
      repeat (4) step();
      ready_mode = 0;
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      check("clear_overflow", 36'(Overflow), 36'(0));
      check("clear_valid", 36'(Valid), 36'(0));

      // full FIFO with a pop exactly on the push cycle
      repeat (4 * 128) step();
      check("full_no_overflow", 36'(Overflow), 36'(0));
      ready_mode = 3;
      repeat (2 * 128) step();
      check("full_pop_push_no_overflow", 36'(Overflow), 36'(0));
      ready_mode = 1;
      repeat (10) step();

      // Enable dropped mid-period keeps the FIFO, then reset empties it
      ready_mode = 0;
      repeat (2 * 128) step();
      repeat ((40 - m_ph + m_P) % m_P) step();
      Enable = 1'b0;
      repeat (5) step();
      check("disabled_sync_low", 36'(Sync), 36'(0));
      check("disabled_fifo_kept", 36'(Valid), 36'(1));
      reset_pulse();
      Enable     = 1'b1;
      ready_mode = 1;
      repeat (300) step();
      check("reenable_first_valid", 36'(first_valid), 36'(138));

      // reset while Sync is high
      repeat ((30 - m_ph + m_P) % m_P) step();
      check("sync_high_before_reset", 36'(Sync), 36'(1));
      reset_pulse();
      repeat (200) step();

      // randomized: data, Ready, Divide (incl. below minimum), Clear, Enable drops
      data_mode  = 2;
      ready_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         Clear = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) == 0) Divide = 10'($urandom_range(0, 400));
         if (!Enable) Enable = 1'b1;
         else if ($urandom_range(0, 599) == 0) Enable = 1'b0;
         step();
      end
      Clear  = 1'b0;
      Enable = 1'b1;
      Divide = 10'd128;
      ready_mode = 1;
      repeat (300) step();

`ifdef ADC_SCHED_AVERAGE_EN
      // averaging by 4: ch0 {-1,-2,-2,-2} -> -2, ch1 constant 5 -> 5
      Enable = 1'b0;
      step();
      Clear = 1'b1;
      step();
      Clear      = 1'b0;
      AvgLog2    = 3'd2;
      data_mode  = 3;
      ready_mode = 0;
      tbl.delete();
      tbl.push_back(36'h0);
      for (int b = 0; b < 2; b++) begin
         tbl.push_back({18'h3FFFF, 18'd5});
         repeat (3) tbl.push_back({18'h3FFFE, 18'd5});
      end
      Enable = 1'b1;
      repeat (128 + 4 * 128 + 20) step();
      check("avg_valid", 36'(Valid), 36'(1));
      check("avg_word", DataOut, {18'h3FFFE, 18'd5});
      repeat (4 * 128) step();
      ready_mode = 1;
      repeat (20) step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
